// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
//   XLEN          : data/address width
//   ILEN          : instruction width
//   fetch_state_e : instruction fetch FSM states
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one instruction-memory request at a time
// from the external PC register, advances that PC by 4 on grant, and holds the
// returned instruction toward decode until accepted. Redirects retarget the PC
// and discard any in-flight response.
//
// Ports:
//   i_clk, i_reset_n              clock, asynchronous active-low reset
//   i_pc_curr                     current PC from the external PC register
//   o_pc_write, o_pc_next         PC register update (combinational)
//   i_redirect, i_redirect_pc     branch/jump/trap redirect pulse and target
//   o_imem_req, o_imem_addr       memory request (combinational)
//   i_imem_gnt                    request accepted this cycle
//   i_imem_rvalid, i_imem_rdata   memory response
//   o_if_valid/o_if_pc/o_if_instr registered instruction toward decode
//   i_id_ready                    decode accepts the instruction this cycle
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned ILEN = riscv_pkg::ILEN
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [XLEN-1:0] i_pc_curr,
  output logic            o_pc_write,
  output logic [XLEN-1:0] o_pc_next,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [ILEN-1:0] i_imem_rdata,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [ILEN-1:0] o_if_instr,
  input  logic            i_id_ready
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_lat_q;
  logic            if_valid_q;
  logic [XLEN-1:0] if_pc_q;
  logic [ILEN-1:0] if_instr_q;

  logic            req;
  logic            grant;
  logic            load_resp;

  assign o_imem_addr = {i_pc_curr[XLEN-1:2], 2'b00};
  assign o_imem_req  = req;
  assign o_if_valid  = if_valid_q;
  assign o_if_pc     = if_pc_q;
  assign o_if_instr  = if_instr_q;

  // Next-state, request and PC-update logic
  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    grant      = 1'b0;
    load_resp  = 1'b0;
    o_pc_write = 1'b0;
    o_pc_next  = i_pc_curr + XLEN'(4);

    unique case (state_q)
      REQ: begin
        // A new request only when decode can take what comes back
        req = !i_redirect && (!if_valid_q || i_id_ready);
        if (req && i_imem_gnt) begin
          grant      = 1'b1;
          o_pc_write = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (i_redirect) begin
          // Response arriving with the redirect is simply discarded
          state_d = i_imem_rvalid ? REQ : DROP;
        end else if (i_imem_rvalid) begin
          load_resp = 1'b1;
          state_d   = REQ;
        end
      end
      DROP: begin
        if (i_imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    // Redirect wins over any sequential PC advance
    if (i_redirect) begin
      o_pc_write = 1'b1;
      o_pc_next  = i_redirect_pc;
    end
  end

  // FSM state register and request PC latch
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= REQ;
      pc_lat_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        pc_lat_q <= i_pc_curr;
      end
    end
  end

  // Decode-facing output register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else if (i_redirect) begin
      if_valid_q <= 1'b0;
    end else if (load_resp) begin
      if_valid_q <= 1'b1;
      if_pc_q    <= pc_lat_q;
      if_instr_q <= i_imem_rdata;
    end else if (if_valid_q && i_id_ready) begin
      if_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [XLEN-1:0] pc_curr;
  logic            pc_write;
  logic [XLEN-1:0] pc_next;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            id_ready;

  logic            pc_load;
  logic [XLEN-1:0] pc_load_val;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  instr_fetch #(.XLEN(XLEN), .ILEN(ILEN)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_pc_curr     (pc_curr),
    .o_pc_write    (pc_write),
    .o_pc_next     (pc_next),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_if_valid    (if_valid),
    .o_if_pc       (if_pc),
    .o_if_instr    (if_instr),
    .i_id_ready    (id_ready)
  );

  always #5 clk = ~clk;

  // External PC register, with a bench-side load port
  always @(posedge clk) begin
    if (pc_load) pc_curr <= pc_load_val;
    else if (pc_write) pc_curr <= pc_next;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset(input logic [XLEN-1:0] pc);
    reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b1;
    pc_load = 1'b1; pc_load_val = pc;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; pc_load = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(32'h4000_0000);
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h exp 0", if_pc); end
    n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h exp 0", if_instr); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req: got %b exp 1", imem_req); end
    n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL reset_pcw: got %b exp 0", pc_write); end
  endtask

  task automatic test_basic;
    imem_gnt = 1'b1; #1;
    n_cmp++; if (imem_addr !== 32'h4000_0000) begin n_err++; $display("FAIL basic_addr: got %h exp 40000000", imem_addr); end
    n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL basic_pcw: got %b exp 1", pc_write); end
    n_cmp++; if (pc_next !== 32'h4000_0004) begin n_err++; $display("FAIL basic_pcnext: got %h exp 40000004", pc_next); end
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    sb.push_back('{pc: 32'h4000_0000, instr: 32'h0000_0013});
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_wait_req: got %b exp 0", imem_req); end
    @(negedge clk);
    imem_rvalid = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b exp 1", if_valid); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL basic_sb: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if (if_pc !== e.pc) begin n_err++; $display("FAIL basic_if_pc: got %h exp %h", if_pc, e.pc); end
      n_cmp++; if (if_instr !== e.instr) begin n_err++; $display("FAIL basic_if_instr: got %h exp %h", if_instr, e.instr); end
    end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_next_req: got %b exp 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h4000_0004) begin n_err++; $display("FAIL basic_next_addr: got %h exp 40000004", imem_addr); end
    @(negedge clk); #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL basic_clear: got %b exp 0", if_valid); end
  endtask

  task automatic test_gnt_stall;
    for (int i = 0; i < 3; i++) begin
      imem_gnt = 1'b0; #1;
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stall_req[%0d]: got %b exp 1", i, imem_req); end
      n_cmp++; if (imem_addr !== 32'h4000_0004) begin n_err++; $display("FAIL stall_addr[%0d]: got %h exp 40000004", i, imem_addr); end
      n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL stall_pcw[%0d]: got %b exp 0", i, pc_write); end
      @(negedge clk);
    end
    imem_gnt = 1'b1; #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL stall_gnt_pcw: got %b exp 1", pc_write); end
    n_cmp++; if (pc_next !== 32'h4000_0008) begin n_err++; $display("FAIL stall_pcnext: got %h exp 40000008", pc_next); end
    @(negedge clk);
    imem_gnt = 1'b0;
  endtask

  // Entered in WAIT with the request for 0x4000_0004 outstanding
  task automatic test_backpressure;
    exp_t h;
    id_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
    sb.push_back('{pc: 32'h4000_0004, instr: 32'h00A0_0093});
    @(negedge clk);
    imem_rvalid = 1'b0;
    h = (sb.size() != 0) ? sb[0] : '0;
    for (int i = 0; i < 4; i++) begin
      imem_gnt = 1'b1; imem_rdata = $urandom; #1;
      n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b exp 1", i, if_valid); end
      n_cmp++; if (if_pc !== h.pc) begin n_err++; $display("FAIL bp_pc[%0d]: got %h exp %h", i, if_pc, h.pc); end
      n_cmp++; if (if_instr !== h.instr) begin n_err++; $display("FAIL bp_instr[%0d]: got %h exp %h", i, if_instr, h.instr); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req[%0d]: got %b exp 0", i, imem_req); end
      n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL bp_pcw[%0d]: got %b exp 0", i, pc_write); end
      @(negedge clk);
    end
    id_ready = 1'b1; imem_gnt = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL bp_release_req: got %b exp 1", imem_req); end
    n_cmp++; if (pc_next !== 32'h4000_000C) begin n_err++; $display("FAIL bp_release_pcnext: got %h exp 4000000c", pc_next); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL bp_sb: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if ({if_pc, if_instr} !== {e.pc, e.instr}) begin n_err++; $display("FAIL bp_pop: got %h/%h exp %h/%h", if_pc, if_instr, e.pc, e.instr); end
    end
    @(negedge clk);
    imem_gnt = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL b2b_clear: got %b exp 0", if_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_8133;
    sb.push_back('{pc: 32'h4000_0008, instr: 32'h0020_8133});
    @(negedge clk);
    imem_rvalid = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b exp 1", if_valid); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL b2b_sb: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if ({if_pc, if_instr} !== {e.pc, e.instr}) begin n_err++; $display("FAIL b2b_pop: got %h/%h exp %h/%h", if_pc, if_instr, e.pc, e.instr); end
    end
    @(negedge clk);
  endtask

  // Entered in REQ, pc = 0x4000_000C, nothing valid
  task automatic test_redirect;
    // Redirect in REQ beats a grant
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h4000_0040; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rdr_req_req: got %b exp 0", imem_req); end
    n_cmp++; if (pc_next !== 32'h4000_0040) begin n_err++; $display("FAIL rdr_req_pcnext: got %h exp 40000040", pc_next); end
    @(negedge clk);
    redirect = 1'b0; imem_gnt = 1'b1; #1;
    n_cmp++; if (imem_addr !== 32'h4000_0040) begin n_err++; $display("FAIL rdr_req_addr: got %h exp 40000040", imem_addr); end
    @(negedge clk);
    // Redirect in WAIT, response two cycles later is dropped
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h4000_0100; #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL rdr_wait_pcw: got %b exp 1", pc_write); end
    n_cmp++; if (pc_next !== 32'h4000_0100) begin n_err++; $display("FAIL rdr_wait_pcnext: got %h exp 40000100", pc_next); end
    @(negedge clk);
    redirect = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rdr_drop_req: got %b exp 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h4000_0100) begin n_err++; $display("FAIL rdr_drop_addr: got %h exp 40000100", imem_addr); end
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rdr_drop_req2: got %b exp 0", imem_req); end
    @(negedge clk);
    imem_rvalid = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rdr_drop_valid: got %b exp 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rdr_after_req: got %b exp 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h4000_0100) begin n_err++; $display("FAIL rdr_after_addr: got %h exp 40000100", imem_addr); end
    // Redirect in WAIT with response in the same cycle
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h4000_0200;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0001;
    @(negedge clk);
    redirect = 1'b0; imem_rvalid = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rdr_same_valid: got %b exp 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rdr_same_req: got %b exp 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h4000_0200) begin n_err++; $display("FAIL rdr_same_addr: got %h exp 40000200", imem_addr); end
    // Redirect while in DROP keeps dropping
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h4000_0300;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h4000_0400; #1;
    n_cmp++; if (pc_next !== 32'h4000_0400) begin n_err++; $display("FAIL rdr_in_drop_pcnext: got %h exp 40000400", pc_next); end
    @(negedge clk);
    redirect = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rdr_in_drop_req: got %b exp 0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0002;
    @(negedge clk);
    imem_rvalid = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rdr_in_drop_valid: got %b exp 0", if_valid); end
    n_cmp++; if (imem_addr !== 32'h4000_0400) begin n_err++; $display("FAIL rdr_in_drop_addr: got %h exp 40000400", imem_addr); end
  endtask

  task automatic test_wrap;
    pc_load = 1'b1; pc_load_val = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_load = 1'b0; imem_gnt = 1'b1; #1;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); end
    n_cmp++; if (pc_next !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pcnext: got %h exp 00000000", pc_next); end
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
    sb.push_back('{pc: 32'hFFFF_FFFC, instr: 32'h0010_0073});
    @(negedge clk);
    imem_rvalid = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid: got %b exp 1", if_valid); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL wrap_sb: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if ({if_pc, if_instr} !== {e.pc, e.instr}) begin n_err++; $display("FAIL wrap_pop: got %h/%h exp %h/%h", if_pc, if_instr, e.pc, e.instr); end
    end
    n_cmp++; if (imem_addr !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_next_addr: got %h exp 00000000", imem_addr); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D; #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rstw_req: got %b exp 1", imem_req); end
    @(negedge clk);
    imem_rvalid = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rstw_valid: got %b exp 0", if_valid); end
    n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rstw_instr: got %h exp 0", if_instr); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rstw_req2: got %b exp 1", imem_req); end
    @(negedge clk); #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rstw_valid2: got %b exp 0", if_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gnt_stall();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_in_wait();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d left exp 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter XLEN, 32, data/address width.
REQ-002 Parameter ILEN, 32, instruction width.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_pc_curr  input  XLEN  current PC from the PC register.
REQ-006 o_pc_write  output  1  PC register update enable.
REQ-007 o_pc_next  output  XLEN  next PC value for the PC register.
REQ-008 i_redirect  input  1  branch/jump/trap redirect pulse from downstream.
REQ-009 i_redirect_pc  input  XLEN  redirect target.
REQ-010 o_imem_req  output  1  instruction memory request valid.
REQ-011 o_imem_addr  output  XLEN  request address, word-aligned.
REQ-012 i_imem_gnt  input  1  request accepted this cycle.
REQ-013 i_imem_rvalid  input  1  response data valid.
REQ-014 i_imem_rdata  input  ILEN  response instruction word.
REQ-015 o_if_valid  output  1  fetched instruction valid toward decode.
REQ-016 o_if_pc  output  XLEN  PC of the fetched instruction.
REQ-017 o_if_instr  output  ILEN  fetched instruction.
REQ-018 i_id_ready  input  1  decode accepts the instruction this cycle.

Function
REQ-019 FSM states SHALL be REQ, WAIT, DROP; at most one memory request outstanding.
REQ-020 o_imem_addr SHALL equal {i_pc_curr[XLEN-1:2], 2'b00}.
REQ-021 REQ: o_imem_req = !i_redirect && (!o_if_valid || i_id_ready).
REQ-022 REQ with o_imem_req && i_imem_gnt: o_pc_write=1, o_pc_next=i_pc_curr+4 (mod 2^XLEN, wraps), latch request PC, go WAIT.
REQ-023 REQ without grant: hold address/request, o_pc_write=0, stay REQ.
REQ-024 WAIT with i_imem_rvalid: next cycle o_if_valid=1, o_if_instr=i_imem_rdata, o_if_pc=latched PC; go REQ.
REQ-025 o_if_valid/o_if_pc/o_if_instr SHALL be stable while o_if_valid && !i_id_ready; cleared on handshake unless reloaded the same cycle.
REQ-026 i_redirect (any state): o_pc_write=1, o_pc_next=i_redirect_pc same cycle; o_if_valid=0 next cycle; redirect overrides any PC+4 write.
REQ-027 Redirect in WAIT without rvalid same cycle -> DROP; with rvalid same cycle, response discarded, go REQ.
REQ-028 DROP: on i_imem_rvalid discard data, go REQ; i_redirect in DROP stays DROP.
REQ-029 Responses SHALL never reach o_if_* in REQ or DROP; rvalid in REQ is ignored.
REQ-030 Max throughput one instruction per two cycles; decode back-pressure only blocks new requests.

Reset
REQ-031 Reset SHALL force state REQ, o_if_valid=0, o_if_pc=0, o_if_instr=0, latched PC=0.
REQ-032 o_imem_req SHALL be 1 in the first cycle after reset release (o_if_valid=0, no redirect).
REQ-033 Reset during WAIT SHALL abandon the outstanding request; a late response after reset is ignored (state REQ).

Structure
REQ-034 Shared package riscv_pkg SHALL hold XLEN, ILEN and fetch_state_e {REQ, WAIT, DROP}.
REQ-035 No sub-module; PC register remains external, driven by o_pc_write/o_pc_next.

Verification
REQ-036 Reset, pc=0x4000_0000, gnt=1, rvalid next cycle, data 0x00000013 -> o_imem_addr 0x4000_0000, o_pc_next 0x4000_0004, o_if_valid with pc 0x4000_0000.
REQ-037 gnt held low 3 cycles -> o_imem_req and address stable, o_pc_write=0 throughout.
REQ-038 o_if_valid=1, i_id_ready=0 for 4 cycles -> outputs stable, o_imem_req=0; ready=1 -> next request issued.
REQ-039 Redirect to 0x4000_0100 in WAIT, rvalid 2 cycles later -> data dropped, o_if_valid=0, next address 0x4000_0100.
REQ-040 pc=0xFFFF_FFFC granted -> o_pc_next=0x0000_0000.
REQ-041 Reset asserted in WAIT, rvalid after release -> o_if_valid stays 0.
